aes_block_packer: RTL and testbench

//  Sits between the two 32-bit host FIFOs and the AES core. Pops four words from the

---
 rtl/aes_fifo_pkg.sv | 29 ++
 rtl/aes_blk_unpacker.sv | 43 ++++
 rtl/aes_block_packer.sv | 116 +++++++++++
 tb/tb_aes_block_packer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_fifo_pkg.sv
// Shared types and helpers for the AES host-FIFO packer.
// Build option AES_PACKER_BYTE_SWAP_EN: byte-reverse each word on ingress and egress.
package aes_fifo_pkg;

  localparam int AES_WORD_W = 32;
  localparam int AES_BLK_W  = 128;

  typedef enum logic [2:0] {
    IDLE,
    GATHER,
    ISSUE,
    WAIT_RES,
    SCATTER
  } state_e;

  function automatic logic [AES_WORD_W-1:0] byte_swap32(input logic [AES_WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Word transform applied at both FIFO boundaries; identity in the default build.
  function automatic logic [AES_WORD_W-1:0] xform_word(input logic [AES_WORD_W-1:0] w);
`ifdef AES_PACKER_BYTE_SWAP_EN
    return byte_swap32(w);
`else
    return w;
`endif
  endfunction

endpackage

// File: rtl/aes_blk_unpacker.sv
// Loads one result block and pushes it word by word, MSW first, honouring FIFO full.
// Egress byte order follows AES_PACKER_BYTE_SWAP_EN through xform_word.
module aes_blk_unpacker
  import aes_fifo_pkg::*;
#(
  parameter int WORDS_PER_BLK = 4
) (
  input  logic                                clk_main_a0,
  input  logic                                rst_main,
  input  logic                                load,
  input  logic [AES_WORD_W*WORDS_PER_BLK-1:0] load_data,
  input  logic                                out_full,
  output logic                                out_wr,
  output logic [AES_WORD_W-1:0]               out_din,
  output logic                                done
);

  localparam int BLK_W = AES_WORD_W * WORDS_PER_BLK;
  localparam int IDX_W = $clog2(WORDS_PER_BLK + 1);

  logic [BLK_W-1:0] shift_q;
  logic [IDX_W-1:0] left_q;

  always_comb begin
    out_wr  = (left_q != '0) && !out_full;
    out_din = xform_word(shift_q[BLK_W-1 -: AES_WORD_W]);
    done    = out_wr && (left_q == IDX_W'(1));
  end

  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      shift_q <= '0;
      left_q  <= '0;
    end else if (load) begin
      shift_q <= load_data;
      left_q  <= IDX_W'(WORDS_PER_BLK);
    end else if (out_wr) begin
      shift_q <= shift_q << AES_WORD_W;
      left_q  <= left_q - IDX_W'(1);
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// Packs host FIFO words into AES blocks and returns results word-serially.
// Build option AES_PACKER_BYTE_SWAP_EN: byte-reverse words at both FIFO boundaries.
//
// state    | meaning
// IDLE     | no block in flight, waiting for host data
// GATHER   | popping and capturing words into the block register
// ISSUE    | block offered to the core until accepted
// WAIT_RES | waiting for the core result
// SCATTER  | result pushed back to the host FIFO
module aes_block_packer
  import aes_fifo_pkg::*;
#(
  parameter int WORDS_PER_BLK = 4,
  parameter int CNT_W         = 16
) (
  input  logic                                clk_main_a0,
  input  logic                                rst_main,
  input  logic                                in_empty,
  output logic                                in_rd,
  input  logic [AES_WORD_W-1:0]               in_dout,
  output logic                                blk_valid,
  input  logic                                blk_ready,
  output logic [AES_WORD_W*WORDS_PER_BLK-1:0] blk_data,
  input  logic                                res_valid,
  output logic                                res_ready,
  input  logic [AES_WORD_W*WORDS_PER_BLK-1:0] res_data,
  input  logic                                out_full,
  output logic                                out_wr,
  output logic [AES_WORD_W-1:0]               out_din,
  output logic                                busy,
  output logic [CNT_W-1:0]                    blk_count
);

  localparam int BLK_W = AES_WORD_W * WORDS_PER_BLK;
  localparam int IDX_W = $clog2(WORDS_PER_BLK + 1);
  localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(WORDS_PER_BLK);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rd_issued, cap_cnt;
  logic             rd_q;
  logic [BLK_W-1:0] blk_reg;
  logic [CNT_W-1:0] cnt_q;
  logic             res_load, scatter_done;

  always_comb begin
    state_d   = state_q;
    in_rd     = 1'b0;
    blk_valid = 1'b0;
    res_ready = 1'b0;
    case (state_q)
      IDLE:     if (!in_empty) state_d = GATHER;
      GATHER: begin
        in_rd = !in_empty && (rd_issued < FULL_CNT);
        if (cap_cnt == FULL_CNT) state_d = ISSUE;
      end
      ISSUE: begin
        blk_valid = 1'b1;
        if (blk_ready) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        res_ready = 1'b1;
        if (res_valid) state_d = SCATTER;
      end
      SCATTER:  if (scatter_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign res_load = res_valid && res_ready;

  // Data lags the pop strobe by one cycle, so capture is keyed off rd_q.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      state_q   <= IDLE;
      rd_issued <= '0;
      cap_cnt   <= '0;
      rd_q      <= 1'b0;
      blk_reg   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= in_rd;
      if (in_rd) rd_issued <= rd_issued + IDX_W'(1);
      if (rd_q) begin
        for (int i = 0; i < WORDS_PER_BLK; i++) begin
          if (cap_cnt == IDX_W'(i))
            blk_reg[BLK_W-1-AES_WORD_W*i -: AES_WORD_W] <= xform_word(in_dout);
        end
        cap_cnt <= cap_cnt + IDX_W'(1);
      end
      if (state_q == IDLE) begin
        rd_issued <= '0;
        cap_cnt   <= '0;
      end
      if (scatter_done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  aes_blk_unpacker #(
    .WORDS_PER_BLK(WORDS_PER_BLK)
  ) u_unpacker (
    .clk_main_a0(clk_main_a0),
    .rst_main   (rst_main),
    .load       (res_load),
    .load_data  (res_data),
    .out_full   (out_full),
    .out_wr     (out_wr),
    .out_din    (out_din),
    .done       (scatter_done)
  );

  assign blk_data  = blk_reg;
  assign busy      = (state_q != IDLE);
  assign blk_count = cnt_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer with host FIFO and echo/xor core models.
// Honours AES_PACKER_BYTE_SWAP_EN when the build defines it.
module tb_aes_block_packer;

  localparam int WPB = 4;

  logic         clk_main_a0 = 1'b0;
  logic         rst_main    = 1'b1;
  logic         in_empty    = 1'b1;
  logic         in_rd;
  logic [31:0]  in_dout     = '0;
  logic         blk_valid;
  logic         blk_ready   = 1'b0;
  logic [127:0] blk_data;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         out_full    = 1'b0;
  logic         out_wr;
  logic [31:0]  out_din;
  logic         busy;
  logic [15:0]  blk_count;

  logic         ready_en = 1'b1, full_force = 1'b0, rand_bp = 1'b0;
  logic         rnd_a = 1'b0, rnd_b = 1'b0;
  logic [127:0] res_mask = '0;

  logic [31:0]  host_mem[$];
  int           host_rp = 0;
  logic [31:0]  pend[$];
  logic [127:0] exp_blk_q[$];
  logic [31:0]  exp_out_q[$];
  logic [127:0] blk_seen[$];
  logic [31:0]  out_q[$];
  int           blk_idx = 0, out_idx = 0;

  int cyc = 0, errors = 0, checks = 0;
  int rd_empty_viol = 0, full_viol = 0, unstable = 0, hs_cnt = 0;
  int first_rd = -1, first_wr = -1;
  logic         prev_bv = 1'b0, prev_hs = 1'b0;
  logic [127:0] prev_bd = '0;

  aes_block_packer #(.WORDS_PER_BLK(WPB), .CNT_W(16)) dut (
    .clk_main_a0(clk_main_a0), .rst_main(rst_main),
    .in_empty(in_empty), .in_rd(in_rd), .in_dout(in_dout),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .out_full(out_full), .out_wr(out_wr), .out_din(out_din),
    .busy(busy), .blk_count(blk_count)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  // Host FIFO with registered flags; all DUT inputs change just after the rising edge.
  always @(posedge clk_main_a0) begin
    int n;
    cyc <= cyc + 1;
    n = host_mem.size() - host_rp;
    if (in_rd && n > 0) begin
      in_dout <= host_mem[host_rp];
      host_rp <= host_rp + 1;
      n--;
    end
    in_empty  <= (n == 0);
    blk_ready <= ready_en & (~rand_bp | rnd_a);
    out_full  <= full_force | (rand_bp & rnd_b);
  end

  // Core: result is the accepted block xor res_mask, valid the cycle after acceptance.
  always @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      if (blk_valid && blk_ready) begin
        res_valid <= 1'b1;
        res_data  <= blk_data ^ res_mask;
      end
    end
  end

  always @(negedge clk_main_a0) begin
    rnd_a <= 1'($urandom_range(0, 1));
    rnd_b <= 1'($urandom_range(0, 1));
  end

  always @(negedge clk_main_a0) begin
    if (!rst_main) begin
      if (in_rd && in_empty) rd_empty_viol++;
      if (out_wr && out_full) full_viol++;
      if (out_wr) out_q.push_back(out_din);
      if (blk_valid && blk_ready) begin
        blk_seen.push_back(blk_data);
        hs_cnt++;
      end
      if (prev_bv && !prev_hs && (!blk_valid || blk_data !== prev_bd)) unstable++;
      prev_bv = blk_valid;
      prev_hs = blk_valid && blk_ready;
      prev_bd = blk_data;
      if (in_rd && first_rd < 0) first_rd = cyc;
      if (out_wr && first_wr < 0) first_wr = cyc;
    end
  end

  function automatic logic [31:0] xw(input logic [31:0] w);
`ifdef AES_PACKER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(negedge clk_main_a0);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: block is the four transformed words MSW first; output is each result word transformed.
  task automatic push_word(input logic [31:0] w);
    logic [127:0] blk, res;
    host_mem.push_back(w);
    pend.push_back(w);
    if (pend.size() == WPB) begin
      blk = '0;
      for (int i = 0; i < WPB; i++) blk = {blk[95:0], xw(pend[i])};
      exp_blk_q.push_back(blk);
      res = blk ^ res_mask;
      for (int i = 0; i < WPB; i++) exp_out_q.push_back(xw(res[127-32*i -: 32]));
      pend.delete();
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    tick();
    while (((out_q.size() - out_idx) < exp_out_q.size() || busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 128'(n < budget), 128'(1));
  endtask

  task automatic check_results(input string tag);
    while (exp_blk_q.size() > 0) begin
      check({tag, "_blk"}, (blk_idx < blk_seen.size()) ? blk_seen[blk_idx] : 'x, exp_blk_q.pop_front());
      blk_idx++;
    end
    while (exp_out_q.size() > 0) begin
      check({tag, "_out"}, (out_idx < out_q.size()) ? 128'(out_q[out_idx]) : 'x, 128'(exp_out_q.pop_front()));
      out_idx++;
    end
    check({tag, "_no_extra_out"}, 128'(out_q.size()), 128'(out_idx));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hs0;

    repeat (3) tick();
    check("rst_ctrl", {in_rd, blk_valid, res_ready, out_wr, busy}, '0);
    check("rst_blk_data", blk_data, '0);
    check("rst_out_din", out_din, '0);
    check("rst_count", blk_count, '0);
    rst_main = 1'b0;
    tick();

    // Basic echo block and minimum latency
    push_word(32'h00112233); push_word(32'h44556677);
    push_word(32'h8899aabb); push_word(32'hccddeeff);
    wait_done("t1", 60);
`ifdef AES_PACKER_BYTE_SWAP_EN
    check("t1_blk_literal", blk_seen.size() > 0 ? blk_seen[0] : 'x, 128'h33221100_77665544_bbaa9988_ffeeddcc);
`else
    check("t1_blk_literal", blk_seen.size() > 0 ? blk_seen[0] : 'x, 128'h00112233_44556677_8899aabb_ccddeeff);
`endif
    check("t1_first_out", out_q.size() > 0 ? 128'(out_q[0]) : 'x, 128'h00112233);
    check_results("t1");
    check("t1_count", blk_count, 16'd1);
    check("t1_latency", 128'(first_wr - first_rd), 128'(WPB + 4));

    // Host FIFO runs dry after two words
    push_word($urandom); push_word($urandom);
    repeat (12) tick();
    check("t2_stall", {busy, blk_valid}, 2'b10);
    push_word($urandom); push_word($urandom);
    wait_done("t2", 60);
    check_results("t2");
    check("t2_rd_while_empty", 128'(rd_empty_viol), '0);
    check("t2_count", blk_count, 16'd2);

    // Core holds off acceptance
    ready_en = 1'b0;
    repeat (4) push_word($urandom);
    n = 0;
    while (!blk_valid && n < 50) begin tick(); n++; end
    hs0 = hs_cnt;
    repeat (5) tick();
    check("t3_valid_held", blk_valid, 1'b1);
    check("t3_data_held", blk_data, exp_blk_q[0]);
    ready_en = 1'b1;
    wait_done("t3", 60);
    check("t3_single_hs", 128'(hs_cnt - hs0), 128'(1));
    check("t3_stable", 128'(unstable), '0);
    check_results("t3");
    check("t3_count", blk_count, 16'd3);

    // Output FIFO full for scatter cycles 1-3
    res_mask = {4{32'h5a5a_0ff0}};
    repeat (4) push_word($urandom);
    n = 0;
    while (!(res_valid && res_ready) && n < 50) begin tick(); n++; end
    tick();
    full_force = 1'b1;
    tick();
    check("t4_hold", {out_wr, out_full}, 2'b01);
    repeat (2) tick();
    full_force = 1'b0;
    wait_done("t4", 60);
    check_results("t4");
    check("t4_wr_while_full", 128'(full_viol), '0);
    check("t4_count", blk_count, 16'd4);

    // Reset in the middle of gathering discards the partial block
    res_mask = '0;
    push_word($urandom); push_word($urandom);
    n = 0;
    while (host_rp != host_mem.size() && n < 50) begin tick(); n++; end
    repeat (2) tick();
    check("t5_busy_before_rst", busy, 1'b1);
    rst_main = 1'b1;
    #1;
    check("t5_rst_ctrl", {in_rd, blk_valid, res_ready, out_wr, busy}, '0);
    check("t5_rst_data", {blk_data, out_din}, '0);
    check("t5_rst_count", blk_count, '0);
    pend.delete();
    repeat (2) tick();
    rst_main = 1'b0;
    tick();
    repeat (4) push_word($urandom);
    wait_done("t5", 60);
    check_results("t5");
    check("t5_count", blk_count, 16'd1);

    // Randomized data, result mask, pacing and back-pressure
    rand_bp = 1'b1;
    for (int b = 0; b < 6; b++) begin
      res_mask = {$urandom, $urandom, $urandom, $urandom};
      for (int w = 0; w < WPB; w++) begin
        push_word($urandom);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_done("rand", 300);
      check_results("rand");
    end
    rand_bp = 1'b0;
    check("rand_count", blk_count, 16'd7);

    // Byte-order pattern
    res_mask = '0;
    repeat (4) push_word(32'h01020304);
    wait_done("t6", 60);
`ifdef AES_PACKER_BYTE_SWAP_EN
    check("t6_blk_literal", blk_idx < blk_seen.size() ? blk_seen[blk_idx] : 'x, {4{32'h04030201}});
`else
    check("t6_blk_literal", blk_idx < blk_seen.size() ? blk_seen[blk_idx] : 'x, {4{32'h01020304}});
`endif
    check("t6_out_literal", out_idx < out_q.size() ? 128'(out_q[out_idx]) : 'x, 128'h01020304);
    check_results("t6");
    check("t6_count", blk_count, 16'd8);

    check("final_rd_while_empty", 128'(rd_empty_viol), '0);
    check("final_wr_while_full", 128'(full_viol), '0);
    check("final_unstable", 128'(unstable), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
